// File: rtl/pause_step_ctrl_pkg.sv
// Shared definitions for the Spectrum pause/step controller: state encoding
// and the default debounce length for front-panel buttons.
package pause_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_STEP   = 2'd2
  } state_t;

  // Roughly 1 ms of stable contact at a 50 MHz system clock.
  localparam int DEB_CYCLES_DEFAULT = 50000;

  function automatic logic releases_cpu(input state_t s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/pause_step_ctrl_if.sv
// Front-panel / host side bundle of the pause controller: buttons, hold level,
// step length in; CPU wait and clock-enable plus status out.
interface pause_step_ctrl_if #(
  parameter int STEP_W = 16
);

  logic              pulsador;
  logic              pulsador_step;
  logic              hold_pause;
  logic [STEP_W-1:0] step_len;
  logic              wait_n;
  logic              enable_clkay;
  logic              paused;
  logic              stepping;

  modport master (
    output pulsador, pulsador_step, hold_pause, step_len,
    input  wait_n, enable_clkay, paused, stepping
  );

  modport slave (
    input  pulsador, pulsador_step, hold_pause, step_len,
    output wait_n, enable_clkay, paused, stepping
  );

endinterface

// File: rtl/pause_step_ctrl_debounce_edge.sv
// Synchronises one raw button, debounces it and emits a single-cycle pulse
// on each rising edge of the debounced level.
module debounce_edge
  import pause_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic evt
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Any cycle where the input agrees with the debounced level restarts the count,
  // so only an unbroken run of DEB_CYCLES disagreeing samples flips the level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 != level) begin
      if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  assign evt = level & ~level_d;

endmodule

// File: rtl/pause_step_ctrl.sv
// Pause controller for the Spectrum core: RUN/PAUSED/STEP state machine that
// stalls the CPU via WAIT_n and gates the ULA/AY clock enable.
module pause_step_ctrl
  import pause_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int STEP_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  pause_step_ctrl_if.slave   bus
);

  logic              evt_pause;
  logic              evt_step;
  state_t            state;
  state_t            state_nx;
  logic [STEP_W-1:0] cnt;
  logic [STEP_W-1:0] cnt_nx;
  logic              wait_q;
  logic              wait_nx;

  debounce_edge #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pause (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (bus.pulsador),
    .evt   (evt_pause)
  );

  debounce_edge #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (bus.pulsador_step),
    .evt   (evt_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_RUN;
      cnt    <= '0;
      wait_q <= 1'b1;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      wait_q <= wait_nx;
    end
  end

  // The step budget only drains on cycles the CPU actually ran (wait_q high),
  // which is what keeps the released-cycle total exact across hold_pause.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_RUN: begin
        if (evt_pause) begin
          state_nx = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (evt_pause) begin
          state_nx = ST_RUN;
        end else if (evt_step && (bus.step_len != '0)) begin
          state_nx = ST_STEP;
          cnt_nx   = bus.step_len;
        end
      end
      ST_STEP: begin
        if (evt_pause) begin
          state_nx = ST_PAUSED;
          cnt_nx   = '0;
        end else if (wait_q) begin
          if (cnt <= STEP_W'(1)) begin
            state_nx = ST_PAUSED;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt - STEP_W'(1);
          end
        end
      end
      default: begin
        state_nx = ST_RUN;
        cnt_nx   = '0;
      end
    endcase
    wait_nx = releases_cpu(state_nx) && !bus.hold_pause;
  end

  assign bus.wait_n       = wait_q;
  assign bus.enable_clkay = wait_q;
  assign bus.paused       = (state == ST_PAUSED);
  assign bus.stepping     = (state == ST_STEP);

endmodule

// File: tb/tb_pause_step_ctrl.sv
// Bench for pause_step_ctrl: directed vector table, multi-cycle corner sequences
// and a randomized run, all checked against a cycle-level behavioural model.
module tb_pause_step_ctrl;

  localparam int DEB = 4;
  localparam int SW  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  pause_step_ctrl_if #(.STEP_W(SW)) bus ();

  pause_step_ctrl #(.DEB_CYCLES(DEB), .STEP_W(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: raw button history, debounced levels, pending rise events,
  // mode (0 run, 1 paused, 2 step), released cycles still owed, wait level.
  bit hist_p[$];
  bit hist_s[$];
  bit m_lvl_p, m_lvl_s, m_rise_p, m_rise_s;
  int m_mode;
  int m_owed;
  bit m_wait;

  typedef struct {
    bit    p;
    bit    s;
    bit    h;
    int    len;
    int    cycles;
    bit    exp_wait;
    bit    exp_paused;
    bit    exp_stepping;
    string name;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Button level flips once the last DEB synchronised samples (raw delayed
  // by two edges, zero before reset release) all disagree with it.
  function automatic bit windowAll(input bit q[$], input bit v);
    int idx;
    bit val;
    windowAll = 1'b1;
    for (int i = 0; i < DEB; i++) begin
      idx = q.size() - 3 - i;
      val = (idx >= 0) ? q[idx] : 1'b0;
      if (val != v) windowAll = 1'b0;
    end
  endfunction

  task automatic modelReset();
    hist_p.delete();
    hist_s.delete();
    m_lvl_p  = 1'b0;
    m_lvl_s  = 1'b0;
    m_rise_p = 1'b0;
    m_rise_s = 1'b0;
    m_mode   = 0;
    m_owed   = 0;
    m_wait   = 1'b1;
  endtask

  task automatic modelEdge();
    bit ep, es, np, ns;
    int nxt;
    ep = m_rise_p;
    es = m_rise_s;
    hist_p.push_back(bus.pulsador);
    hist_s.push_back(bus.pulsador_step);
    if (hist_p.size() > 32) begin
      void'(hist_p.pop_front());
      void'(hist_s.pop_front());
    end
    np = windowAll(hist_p, !m_lvl_p) ? !m_lvl_p : m_lvl_p;
    ns = windowAll(hist_s, !m_lvl_s) ? !m_lvl_s : m_lvl_s;
    m_rise_p = np && !m_lvl_p;
    m_rise_s = ns && !m_lvl_s;
    m_lvl_p  = np;
    m_lvl_s  = ns;
    nxt = m_mode;
    if (m_mode == 0) begin
      if (ep) nxt = 1;
    end else if (m_mode == 1) begin
      if (ep) nxt = 0;
      else if (es && bus.step_len != 0) begin
        nxt    = 2;
        m_owed = int'(bus.step_len);
      end
    end else begin
      if (ep) begin
        nxt    = 1;
        m_owed = 0;
      end else if (m_wait) begin
        m_owed = m_owed - 1;
        if (m_owed == 0) nxt = 1;
      end
    end
    m_mode = nxt;
    m_wait = (nxt != 1) && !bus.hold_pause;
  endtask

  task automatic checkModel();
    checkOutput("model.wait_n", bus.wait_n, m_wait);
    checkOutput("model.enable_clkay", bus.enable_clkay, m_wait);
    checkOutput("model.paused", bus.paused, m_mode == 1);
    checkOutput("model.stepping", bus.stepping, m_mode == 2);
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkModel();
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.pulsador      = v.p;
    bus.pulsador_step = v.s;
    bus.hold_pause    = v.h;
    bus.step_len      = SW'(v.len);
    repeat (v.cycles) tick();
    checkOutput({v.name, ".wait_n"}, bus.wait_n, v.exp_wait);
    checkOutput({v.name, ".paused"}, bus.paused, v.exp_paused);
    checkOutput({v.name, ".stepping"}, bus.stepping, v.exp_stepping);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int highs, lows, guard;

    //            p  s  h  len cyc  w  pa st
    vecs.push_back('{0, 0, 0, 0, 3,  1, 0, 0, "reset_idle"});
    vecs.push_back('{1, 0, 0, 0, 6,  1, 0, 0, "press1_early"});
    vecs.push_back('{1, 0, 0, 0, 1,  0, 1, 0, "press1_edge7"});
    vecs.push_back('{0, 0, 0, 0, 10, 0, 1, 0, "press1_release"});
    vecs.push_back('{1, 0, 0, 0, 7,  1, 0, 0, "press2_toggle"});
    vecs.push_back('{0, 0, 0, 0, 10, 1, 0, 0, "press2_release"});
    vecs.push_back('{1, 0, 0, 0, 3,  1, 0, 0, "bounce_hi1"});
    vecs.push_back('{0, 0, 0, 0, 2,  1, 0, 0, "bounce_lo"});
    vecs.push_back('{1, 0, 0, 0, 3,  1, 0, 0, "bounce_hi2"});
    vecs.push_back('{0, 0, 0, 0, 10, 1, 0, 0, "bounce_quiet"});
    vecs.push_back('{1, 0, 0, 0, 6,  1, 0, 0, "stable_6"});
    vecs.push_back('{1, 0, 0, 0, 4,  0, 1, 0, "stable_10"});
    vecs.push_back('{0, 0, 0, 0, 10, 0, 1, 0, "stable_once"});
    vecs.push_back('{0, 1, 0, 5, 6,  0, 1, 0, "step5_early"});
    vecs.push_back('{0, 1, 0, 5, 1,  1, 0, 1, "step5_enter"});
    vecs.push_back('{0, 1, 0, 5, 4,  1, 0, 1, "step5_fifth"});
    vecs.push_back('{0, 1, 0, 5, 1,  0, 1, 0, "step5_done"});
    vecs.push_back('{0, 0, 0, 5, 10, 0, 1, 0, "step5_release"});
    vecs.push_back('{0, 1, 0, 0, 10, 0, 1, 0, "step0_ignored"});
    vecs.push_back('{0, 0, 0, 0, 10, 0, 1, 0, "step0_release"});

    bus.pulsador      = 1'b0;
    bus.pulsador_step = 1'b0;
    bus.hold_pause    = 1'b0;
    bus.step_len      = '0;
    #1 rst_n = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset.wait_n", bus.wait_n, 1);
    checkOutput("reset.enable_clkay", bus.enable_clkay, 1);
    checkOutput("reset.paused", bus.paused, 0);
    checkOutput("reset.stepping", bus.stepping, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Step of 6 with hold_pause masking three cycles in the middle.
    bus.step_len      = 8'd6;
    bus.pulsador_step = 1'b1;
    highs = 0;
    lows  = 0;
    repeat (9) begin
      tick();
      if (bus.wait_n) highs++;
    end
    bus.hold_pause = 1'b1;
    repeat (3) begin
      tick();
      if (!bus.wait_n) lows++;
    end
    bus.hold_pause = 1'b0;
    guard = 0;
    while (bus.stepping && guard < 30) begin
      tick();
      if (bus.wait_n) highs++;
      guard++;
    end
    checkOutput("hold.low_cycles", lows, 3);
    checkOutput("hold.high_cycles", highs, 6);
    checkOutput("hold.within_bound", guard < 30, 1);
    checkOutput("hold.end_paused", bus.paused, 1);
    bus.pulsador_step = 1'b0;
    repeat (10) tick();

    // Long step aborted by pause, then simultaneous pause+step from PAUSED.
    bus.step_len      = 8'd200;
    bus.pulsador_step = 1'b1;
    repeat (7) tick();
    checkOutput("abort.stepping", bus.stepping, 1);
    bus.pulsador_step = 1'b0;
    repeat (20) tick();
    bus.pulsador = 1'b1;
    repeat (6) tick();
    checkOutput("abort.still_stepping", bus.stepping, 1);
    tick();
    checkOutput("abort.paused", bus.paused, 1);
    checkOutput("abort.wait_n", bus.wait_n, 0);
    bus.pulsador = 1'b0;
    repeat (10) tick();
    checkOutput("abort.stays_paused", bus.paused, 1);
    bus.pulsador      = 1'b1;
    bus.pulsador_step = 1'b1;
    repeat (7) tick();
    checkOutput("both.paused", bus.paused, 0);
    checkOutput("both.stepping", bus.stepping, 0);
    checkOutput("both.wait_n", bus.wait_n, 1);
    bus.pulsador      = 1'b0;
    bus.pulsador_step = 1'b0;
    repeat (10) tick();

    // Asynchronous reset in the middle of a step, step button kept held.
    bus.pulsador = 1'b1;
    repeat (7) tick();
    bus.pulsador = 1'b0;
    repeat (10) tick();
    bus.step_len      = 8'd50;
    bus.pulsador_step = 1'b1;
    repeat (7) tick();
    checkOutput("arst.pre_stepping", bus.stepping, 1);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst.wait_n", bus.wait_n, 1);
    checkOutput("arst.enable_clkay", bus.enable_clkay, 1);
    checkOutput("arst.paused", bus.paused, 0);
    checkOutput("arst.stepping", bus.stepping, 0);
    modelReset();
    #1 rst_n = 1'b1;
    repeat (20) tick();
    checkOutput("arst.after_paused", bus.paused, 0);
    checkOutput("arst.after_stepping", bus.stepping, 0);
    checkOutput("arst.after_wait_n", bus.wait_n, 1);
    bus.pulsador_step = 1'b0;
    repeat (10) tick();

    // Randomized traffic: toggling buttons (short runs act as bounce),
    // sporadic hold_pause and changing step lengths.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 29) == 0) bus.pulsador = ~bus.pulsador;
      if ($urandom_range(0, 24) == 0) bus.pulsador_step = ~bus.pulsador_step;
      bus.hold_pause = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) bus.step_len = SW'($urandom_range(0, 12));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
